com_uart: RTL and testbench

- Serial-port endpoint at the far end of the memory controller's COM interface.
- Accepts byte writes issued by the controller at COM data address 0x1FD003F8.
- Serialises received bytes and delivers them with the ready flags that the controller exposes at COM status address 0x1FD003FC.
- Format: 8N1 UART, LSB first, fixed baud derived from clk50M.

---
 rtl/com_uart.sv | 250 +++++++++++++++++++++++++
 tb/tb_com_uart.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/com_uart.sv
// com_uart: 8N1 UART endpoint behind the memory controller COM port (data 0x1FD003F8, status 0x1FD003FC).
// Define COM_RX_OVERRUN_EN to add the rx_overrun flag; without it overrun is silent.
module com_uart #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_ack,
`ifdef COM_RX_OVERRUN_EN
    output logic       rx_overrun,
`endif
    input  logic       uart_rxd,
    output logic       uart_txd
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    state_e             tx_state_q, tx_state_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]         tx_bit_q, tx_bit_d;
    logic [7:0]         tx_shift_q, tx_shift_d;
    logic               txd_q, txd_d;
    logic               tx_ready_q, tx_ready_d;

    logic               rxd_meta_q, rxd_sync_q;
    state_e             rx_state_q, rx_state_d;
    logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic               rx_ferr_q, rx_ferr_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_ready_q, rx_ready_d;
    logic               rx_done_c;

    logic tx_bit_end;
    logic rx_bit_end;

    assign tx_bit_end = (tx_cnt_q == LAST_CNT);
    assign rx_bit_end = (rx_cnt_q == LAST_CNT);

    // Transmitter: latch byte in IDLE, then start, 8 data bits LSB first, stop.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_ready_d = tx_ready_q;
        case (tx_state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    tx_shift_d = tx_data;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = 1'b0;
                    tx_ready_d = 1'b0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    txd_d      = tx_shift_q[0];
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_ready_d = 1'b1;
                    tx_state_d = ST_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                txd_d      = 1'b1;
                tx_ready_d = 1'b1;
                tx_state_d = ST_IDLE;
            end
        endcase
    end

    // Receiver: mid-bit sampling on the synchronised line; a completed byte beats a same-edge ack.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_ferr_d  = rx_ferr_q;
        rx_data_d  = rx_data_q;
        rx_ready_d = rx_ready_q;
        rx_done_c  = 1'b0;
        if (rx_ack && rx_ready_q) begin
            rx_ready_d = 1'b0;
        end
        case (rx_state_q)
            ST_IDLE: begin
                if (!rxd_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF_CNT) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (rx_ferr_q) begin
                    // Framing error: byte already dropped, just wait for the line to idle.
                    if (rxd_sync_q) begin
                        rx_ferr_d  = 1'b0;
                        rx_state_d = ST_IDLE;
                    end
                end else if (rx_bit_end) begin
                    rx_cnt_d = '0;
                    if (rxd_sync_q) begin
                        rx_done_c  = 1'b1;
                        rx_data_d  = rx_shift_q;
                        rx_ready_d = 1'b1;
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                rx_ferr_d  = 1'b0;
                rx_state_d = ST_IDLE;
            end
        endcase
    end

`ifdef COM_RX_OVERRUN_EN
    logic rx_overrun_q, rx_overrun_d;

    // Sticky overrun: set when an unacked pending byte is overwritten, cleared with rx_ready.
    always_comb begin
        rx_overrun_d = rx_overrun_q;
        if (rx_ack && rx_ready_q) begin
            rx_overrun_d = 1'b0;
        end
        if (rx_done_c && rx_ready_q && !rx_ack) begin
            rx_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            rx_overrun_q <= 1'b0;
        end else begin
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign rx_overrun = rx_overrun_q;
`endif

    always_ff @(posedge clk50M) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_ferr_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            tx_ready_q <= tx_ready_d;
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    assign uart_txd = txd_q;
    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_ready = rx_ready_q;

endmodule

// File: tb/tb_com_uart.sv
// Testbench for com_uart at CLKS_PER_BIT=8: TX vector table, RX scoreboard, collisions, loopback.
module tb_com_uart;

    localparam int CPB = 8;

    logic       clk50M = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ack;
    logic       uart_rxd;
    logic       uart_txd;
`ifdef COM_RX_OVERRUN_EN
    logic       rx_overrun;
`endif

    logic       rxd_drv;
    logic       loop_en;
    logic       mon_en;
    logic       auto_ack;
    logic       rdy_prev;
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    always #10 clk50M = ~clk50M;

    assign uart_rxd = loop_en ? uart_txd : rxd_drv;

    com_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk50M   (clk50M),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_ack   (rx_ack),
`ifdef COM_RX_OVERRUN_EN
        .rx_overrun(rx_overrun),
`endif
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;    // bit 0 is the first bit on the wire
        logic       inject;  // issue a 0x3C tx_start mid-frame
    } tx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
    } rx_vec_t;

    tx_vec_t    tv[4];
    rx_vec_t    rv[5];
    logic [7:0] lb[3];
    logic [7:0] last_good;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock; also pops the scoreboard on each rx_ready rising edge.
    task automatic tick();
        @(posedge clk50M);
        #1;
        if (auto_ack) rx_ack = 1'b0;
        if (mon_en && rx_ready && !rdy_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got 0x%0h expected no byte at %0t", rx_data, $time);
            end else begin
                chk("rx_byte", 32'(rx_data), 32'(exp_q.pop_front()));
            end
            if (auto_ack) rx_ack = 1'b1;
        end
        rdy_prev = rx_ready;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rx_bits(input logic [7:0] b);
        rxd_drv = 1'b0;
        ticks(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            ticks(CPB);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx_bits(b);
        rxd_drv = stop;
        ticks(CPB);
        rxd_drv = 1'b1;
        ticks(4);
    endtask

    task automatic wait_tx_ready(input int budget);
        int n = 0;
        while (!tx_ready && n < budget) begin
            tick();
            n++;
        end
        chk("tx_ready_wait", 32'(tx_ready), 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("rx_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic tx_send(input logic [7:0] b);
        tx_data  = b;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00; rx_ack = 1'b0; rxd_drv = 1'b1;
        loop_en = 1'b0; mon_en = 1'b0; auto_ack = 1'b0; rdy_prev = 1'b0;

        // Reset state
        ticks(3);
        chk("rst_txd", 32'(uart_txd), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
`ifdef COM_RX_OVERRUN_EN
        chk("rst_overrun", 32'(rx_overrun), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // TX vector table: line = {stop, data, start}
        tv[0] = '{8'hA5, 10'b1101001010, 1'b0};
        tv[1] = '{8'hA5, 10'b1101001010, 1'b1};
        tv[2] = '{8'h01, 10'b1000000010, 1'b0};
        tv[3] = '{8'hFE, 10'b1111111100, 1'b0};
        for (int v = 0; v < 4; v++) begin
            tx_send(tv[v].data);
            tx_data = 8'h00;
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < CPB; c++) begin
                    chk("tx_line", 32'(uart_txd), 32'(tv[v].line[b]));
                    chk("tx_busy", 32'(tx_ready), 32'd0);
                    if (tv[v].inject && b == 3 && c == 2) begin
                        tx_data  = 8'h3C;
                        tx_start = 1'b1;
                    end
                    tick();
                    tx_start = 1'b0;
                end
            end
            chk("tx_ready_after", 32'(tx_ready), 32'd1);
            chk("tx_idle", 32'(uart_txd), 32'd1);
            ticks(3);
            chk("tx_idle_hold", 32'(uart_txd), 32'd1);
            chk("tx_ready_hold", 32'(tx_ready), 32'd1);
        end

        // RX vector table with scoreboard; stop=0 rows are framing errors
        rv[0] = '{8'h00, 1'b1};
        rv[1] = '{8'hFF, 1'b1};
        rv[2] = '{8'h81, 1'b0};
        rv[3] = '{8'h42, 1'b1};
        rv[4] = '{8'h96, 1'b1};
        mon_en = 1'b1; auto_ack = 1'b1;
        last_good = 8'h00;
        for (int i = 0; i < 5; i++) begin
            if (rv[i].stop) begin
                exp_q.push_back(rv[i].data);
                last_good = rv[i].data;
            end
            send_rx(rv[i].data, rv[i].stop);
            ticks(2);
            chk("rx_data_hold", 32'(rx_data), 32'(last_good));
            if (!rv[i].stop) chk("rx_ferr_ready", 32'(rx_ready), 32'd0);
        end
        wait_drain(50);

        // 0x5A with exact latency, then a 4-cycle ack
        auto_ack = 1'b0;
        exp_q.push_back(8'h5A);
        rx_bits(8'h5A);
        rxd_drv = 1'b1;
        ticks(CPB / 2 + 3);
        chk("rx_latency_early", 32'(rx_ready), 32'd0);
        tick();
        chk("rx_latency", 32'(rx_ready), 32'd1);
        chk("rx_data_5a", 32'(rx_data), 32'h5A);
        ticks(4);
        rx_ack = 1'b1;
        tick();
        chk("rx_ack_clear", 32'(rx_ready), 32'd0);
        chk("rx_ack_data", 32'(rx_data), 32'h5A);
        ticks(3);
        rx_ack = 1'b0;
        tick();
        chk("rx_ack_hold", 32'(rx_data), 32'h5A);

        // Short low glitch is a false start
        rxd_drv = 1'b0;
        ticks(3);
        rxd_drv = 1'b1;
        ticks(20);
        chk("glitch_ready", 32'(rx_ready), 32'd0);
        chk("glitch_data", 32'(rx_data), 32'h5A);

        // Collision: 0x22 completes on the same edge as the ack of pending 0x11
        mon_en = 1'b0;
        send_rx(8'h11, 1'b1);
        chk("col_11_ready", 32'(rx_ready), 32'd1);
        chk("col_11_data", 32'(rx_data), 32'h11);
        rx_bits(8'h22);
        rxd_drv = 1'b1;
        ticks(CPB / 2 + 3);
        chk("col_pending", 32'(rx_data), 32'h11);
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        chk("col_ready", 32'(rx_ready), 32'd1);
        chk("col_data", 32'(rx_data), 32'h22);
`ifdef COM_RX_OVERRUN_EN
        chk("col_overrun", 32'(rx_overrun), 32'd0);
`endif
        ticks(4);
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        chk("col_cleared", 32'(rx_ready), 32'd0);

        // Overwrite without ack
        send_rx(8'h44, 1'b1);
        chk("ovr_44_data", 32'(rx_data), 32'h44);
`ifdef COM_RX_OVERRUN_EN
        chk("ovr_pre", 32'(rx_overrun), 32'd0);
`endif
        send_rx(8'h33, 1'b1);
        chk("ovr_ready", 32'(rx_ready), 32'd1);
        chk("ovr_data", 32'(rx_data), 32'h33);
`ifdef COM_RX_OVERRUN_EN
        chk("ovr_flag", 32'(rx_overrun), 32'd1);
`endif
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        chk("ovr_ack_ready", 32'(rx_ready), 32'd0);
        chk("ovr_ack_data", 32'(rx_data), 32'h33);
`ifdef COM_RX_OVERRUN_EN
        chk("ovr_ack_flag", 32'(rx_overrun), 32'd0);
`endif

        // Loopback, back-to-back bytes
        loop_en = 1'b1; mon_en = 1'b1; auto_ack = 1'b1;
        rdy_prev = rx_ready;
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h7E;
        for (int i = 0; i < 3; i++) begin
            wait_tx_ready(200);
            exp_q.push_back(lb[i]);
            tx_send(lb[i]);
        end
        wait_drain(300);
        chk("lb_last", 32'(rx_data), 32'h7E);

        // Reset mid-frame aborts, then 0xC3 goes through
        wait_tx_ready(200);
        tx_send(8'h99);
        ticks(35);
        chk("abort_busy", 32'(tx_ready), 32'd0);
        rst = 1'b1;
        tick();
        chk("abort_txd", 32'(uart_txd), 32'd1);
        chk("abort_tx_ready", 32'(tx_ready), 32'd1);
        chk("abort_rx_ready", 32'(rx_ready), 32'd0);
        chk("abort_rx_data", 32'(rx_data), 32'h00);
        ticks(2);
        rst = 1'b0;
        ticks(3 * CPB);
        chk("abort_no_byte", 32'(rx_ready), 32'd0);
        wait_tx_ready(10);
        exp_q.push_back(8'hC3);
        tx_send(8'hC3);
        wait_drain(300);
        chk("lb_c3", 32'(rx_data), 32'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
